// File: rtl/text_writer.sv
// rtl/text_writer.sv - keyboard-code to character-RAM writer with cursor and clear sweep; optional arrows via TEXT_WRITER_ARROWS_EN
module text_writer #(
    parameter int COLS      = 40,
    parameter int ROWS      = 15,
    parameter int CODE_W    = 10,
    parameter int DATA_W    = 10,
    parameter int PRINT_MAX = 38,
    localparam int ADDR_W   = $clog2(COLS*ROWS),
    localparam int COL_W    = $clog2(COLS),
    localparam int ROW_W    = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [CODE_W-1:0] teclado,
    input  logic              done,
    output logic [ADDR_W-1:0] address,
    output logic              en_mem,
    output logic [DATA_W-1:0] wr_data_mem,
    output logic              busy,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row
);

    // One extra bit so the sweep counter can reach COLS*ROWS even when it is a power of two
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  L_CELLS    = CNT_W'(COLS*ROWS);
    localparam logic [COL_W-1:0]  L_COL_LAST = COL_W'(COLS-1);
    localparam logic [ROW_W-1:0]  L_ROW_LAST = ROW_W'(ROWS-1);

    localparam logic [CODE_W-1:0] K_BREAK = CODE_W'(12'h0F0);
    localparam logic [CODE_W-1:0] K_EXT   = CODE_W'(12'h0E0);
    localparam logic [CODE_W-1:0] K_ENTER = CODE_W'(12'h0C0);
    localparam logic [CODE_W-1:0] K_BKSP  = CODE_W'(12'h108);
    localparam logic [CODE_W-1:0] K_PRINT = CODE_W'(PRINT_MAX);
`ifdef TEXT_WRITER_ARROWS_EN
    localparam logic [CODE_W-1:0] K_LEFT  = CODE_W'(12'h06B);
    localparam logic [CODE_W-1:0] K_RIGHT = CODE_W'(12'h074);
    localparam logic [CODE_W-1:0] K_UP    = CODE_W'(12'h075);
    localparam logic [CODE_W-1:0] K_DOWN  = CODE_W'(12'h072);
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [COL_W-1:0]  r_col, w_col_nxt;
    logic [ROW_W-1:0]  r_row, w_row_nxt;
    logic              r_ign, w_ign_nxt;
    logic              r_ext, w_ext_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_en, w_en_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;

    // Neighbouring cursor positions used by printable, Enter, Backspace and arrows
    logic [ROW_W-1:0]  w_row_inc, w_row_dec;
    logic [COL_W-1:0]  w_adv_col, w_ret_col;
    logic [ROW_W-1:0]  w_adv_row, w_ret_row;
    logic [ADDR_W-1:0] w_cur_addr, w_ret_addr;

    assign w_row_inc  = (r_row == L_ROW_LAST) ? '0 : r_row + 1'b1;
    assign w_row_dec  = (r_row == '0) ? L_ROW_LAST : r_row - 1'b1;
    assign w_adv_col  = (r_col == L_COL_LAST) ? '0 : r_col + 1'b1;
    assign w_adv_row  = (r_col == L_COL_LAST) ? w_row_inc : r_row;
    assign w_ret_col  = (r_col == '0) ? L_COL_LAST : r_col - 1'b1;
    assign w_ret_row  = (r_col == '0) ? w_row_dec : r_row;
    assign w_cur_addr = ADDR_W'(int'(r_row) * COLS + int'(r_col));
    assign w_ret_addr = ADDR_W'(int'(w_ret_row) * COLS + int'(w_ret_col));

    // Next-state, cursor, flag and write-port decode
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_ign_nxt   = r_ign;
        w_ext_nxt   = r_ext;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_en_nxt    = 1'b0;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    // First sweep write is issued here so address 0 appears the next cycle
                    w_state_nxt = S_CLEAR;
                    w_en_nxt    = 1'b1;
                    w_addr_nxt  = '0;
                    w_data_nxt  = '0;
                    w_cnt_nxt   = CNT_W'(1);
                end else if (done) begin
                    if (r_ign) begin
                        w_ign_nxt = 1'b0;
                        w_ext_nxt = 1'b0;
                    end else if (teclado == K_BREAK) begin
                        w_ign_nxt = 1'b1;
                    end else if (teclado == K_EXT) begin
                        w_ext_nxt = 1'b1;
                    end else if (r_ext) begin
                        w_ext_nxt = 1'b0;
`ifdef TEXT_WRITER_ARROWS_EN
                        if (teclado == K_LEFT) begin
                            w_col_nxt = w_ret_col;
                            w_row_nxt = w_ret_row;
                        end else if (teclado == K_RIGHT) begin
                            w_col_nxt = w_adv_col;
                            w_row_nxt = w_adv_row;
                        end else if (teclado == K_UP) begin
                            w_row_nxt = w_row_dec;
                        end else if (teclado == K_DOWN) begin
                            w_row_nxt = w_row_inc;
                        end
`endif
                    end else if (teclado < K_PRINT) begin
                        w_en_nxt   = 1'b1;
                        w_addr_nxt = w_cur_addr;
                        w_data_nxt = DATA_W'(teclado);
                        w_col_nxt  = w_adv_col;
                        w_row_nxt  = w_adv_row;
                    end else if (teclado == K_ENTER) begin
                        w_col_nxt = '0;
                        w_row_nxt = w_row_inc;
                    end else if (teclado == K_BKSP) begin
                        w_en_nxt   = 1'b1;
                        w_addr_nxt = w_ret_addr;
                        w_data_nxt = '0;
                        w_col_nxt  = w_ret_col;
                        w_row_nxt  = w_ret_row;
                    end
                end
            end
            S_CLEAR: begin
                if (r_cnt == L_CELLS) begin
                    w_state_nxt = S_IDLE;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_ign_nxt   = 1'b0;
                    w_ext_nxt   = 1'b0;
                end else begin
                    w_en_nxt   = 1'b1;
                    w_addr_nxt = r_cnt[ADDR_W-1:0];
                    w_data_nxt = '0;
                    w_cnt_nxt  = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers; reset overrides all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_ign   <= 1'b0;
            r_ext   <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_en    <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_ign   <= w_ign_nxt;
            r_ext   <= w_ext_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_en    <= w_en_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign address     = r_addr;
    assign en_mem      = r_en;
    assign wr_data_mem = r_data;
    assign busy        = (r_state == S_CLEAR);
    assign cursor_col  = r_col;
    assign cursor_row  = r_row;

endmodule

// File: tb/tb_text_writer.sv
// tb/tb_text_writer.sv - directed self-checking bench for text_writer
module tb_text_writer;

`ifdef TEXT_WRITER_ARROWS_EN
    localparam bit ARROWS = 1'b1;
`else
    localparam bit ARROWS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [9:0] teclado = '0;
    logic       done = 1'b0;
    logic [9:0] address;
    logic       en_mem;
    logic [9:0] wr_data_mem;
    logic       busy;
    logic [5:0] cursor_col;
    logic [3:0] cursor_row;

    int n_vec = 0;
    int n_bad = 0;

    text_writer dut (
        .clk(clk), .rst(rst), .clear(clear), .teclado(teclado), .done(done),
        .address(address), .en_mem(en_mem), .wr_data_mem(wr_data_mem),
        .busy(busy), .cursor_col(cursor_col), .cursor_row(cursor_row)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One done strobe; returns at the negedge where its effect is visible
    task automatic key(input logic [9:0] code);
        @(negedge clk);
        teclado = code;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        done = 1'b1;
        teclado = 10'h005;
        clear = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        done = 1'b0;
        clear = 1'b0;
        n_vec++; if (address !== 10'd0) begin n_bad++; $display("FAIL rst_addr got=%0d exp=0", address); end
        n_vec++; if (en_mem !== 1'b0) begin n_bad++; $display("FAIL rst_en got=%0b exp=0", en_mem); end
        n_vec++; if (wr_data_mem !== 10'd0) begin n_bad++; $display("FAIL rst_data got=%0h exp=0", wr_data_mem); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        n_vec++; if (cursor_col !== 6'd0 || cursor_row !== 4'd0) begin n_bad++; $display("FAIL rst_cursor got=(%0d,%0d) exp=(0,0)", cursor_col, cursor_row); end
    endtask

    task automatic test_print_first();
        key(10'h005);
        n_vec++; if (en_mem !== 1'b1) begin n_bad++; $display("FAIL p1_en got=%0b exp=1", en_mem); end
        n_vec++; if (address !== 10'd0) begin n_bad++; $display("FAIL p1_addr got=%0d exp=0", address); end
        n_vec++; if (wr_data_mem !== 10'h005) begin n_bad++; $display("FAIL p1_data got=%0h exp=5", wr_data_mem); end
        n_vec++; if (cursor_col !== 6'd1 || cursor_row !== 4'd0) begin n_bad++; $display("FAIL p1_cursor got=(%0d,%0d) exp=(1,0)", cursor_col, cursor_row); end
        @(negedge clk);
        n_vec++; if (en_mem !== 1'b0) begin n_bad++; $display("FAIL p1_en_drop got=%0b exp=0", en_mem); end
    endtask

    task automatic test_wrap();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            key(10'(i % 37 + 1));
            if (en_mem !== 1'b1 || address !== 10'(i) || wr_data_mem !== 10'(i % 37 + 1)) bad++;
        end
        n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL row0_writes bad_cycles=%0d exp=0", bad); end
        n_vec++; if (cursor_col !== 6'd0 || cursor_row !== 4'd1) begin n_bad++; $display("FAIL row0_cursor got=(%0d,%0d) exp=(0,1)", cursor_col, cursor_row); end
        key(10'h001);
        n_vec++; if (address !== 10'd40 || en_mem !== 1'b1) begin n_bad++; $display("FAIL w41_addr got=%0d en=%0b exp=40 en=1", address, en_mem); end
        n_vec++; if (cursor_col !== 6'd1 || cursor_row !== 4'd1) begin n_bad++; $display("FAIL w41_cursor got=(%0d,%0d) exp=(1,1)", cursor_col, cursor_row); end
        key(10'h0C0);
        n_vec++; if (en_mem !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 4'd2) begin n_bad++; $display("FAIL enter got=en%0b (%0d,%0d) exp=en0 (0,2)", en_mem, cursor_col, cursor_row); end
        repeat (12) key(10'h0C0);
        repeat (39) key(10'h002);
        n_vec++; if (cursor_col !== 6'd39 || cursor_row !== 4'd14) begin n_bad++; $display("FAIL last_cursor got=(%0d,%0d) exp=(39,14)", cursor_col, cursor_row); end
        key(10'h025);
        n_vec++; if (address !== 10'd599 || wr_data_mem !== 10'h025 || en_mem !== 1'b1) begin n_bad++; $display("FAIL w599 got=addr%0d data%0h en%0b exp=addr599 data25 en1", address, wr_data_mem, en_mem); end
        n_vec++; if (cursor_col !== 6'd0 || cursor_row !== 4'd0) begin n_bad++; $display("FAIL screen_wrap got=(%0d,%0d) exp=(0,0)", cursor_col, cursor_row); end
    endtask

    task automatic test_backspace();
        key(10'h108);
        n_vec++; if (en_mem !== 1'b1 || address !== 10'd599 || wr_data_mem !== 10'd0) begin n_bad++; $display("FAIL bksp got=en%0b addr%0d data%0h exp=en1 addr599 data0", en_mem, address, wr_data_mem); end
        n_vec++; if (cursor_col !== 6'd39 || cursor_row !== 4'd14) begin n_bad++; $display("FAIL bksp_cursor got=(%0d,%0d) exp=(39,14)", cursor_col, cursor_row); end
        key(10'h0F0);
        n_vec++; if (en_mem !== 1'b0) begin n_bad++; $display("FAIL break_en got=%0b exp=0", en_mem); end
        key(10'h005);
        n_vec++; if (en_mem !== 1'b0 || cursor_col !== 6'd39 || cursor_row !== 4'd14) begin n_bad++; $display("FAIL break_drop got=en%0b (%0d,%0d) exp=en0 (39,14)", en_mem, cursor_col, cursor_row); end
        n_vec++; if (address !== 10'd599 || wr_data_mem !== 10'd0) begin n_bad++; $display("FAIL hold got=addr%0d data%0h exp=addr599 data0", address, wr_data_mem); end
        key(10'h050);
        n_vec++; if (en_mem !== 1'b0 || cursor_col !== 6'd39 || cursor_row !== 4'd14) begin n_bad++; $display("FAIL other_code got=en%0b (%0d,%0d) exp=en0 (39,14)", en_mem, cursor_col, cursor_row); end
        key(10'h004);
        n_vec++; if (en_mem !== 1'b1 || address !== 10'd599 || wr_data_mem !== 10'h004) begin n_bad++; $display("FAIL after_other got=en%0b addr%0d data%0h exp=en1 addr599 data4", en_mem, address, wr_data_mem); end
    endtask

    task automatic test_arrows();
        logic [5:0] ec;
        logic [3:0] er;
        do_reset();
        key(10'h0C0);
        key(10'h0C0);
        key(10'h001);
        key(10'h002);
        key(10'h003);
        n_vec++; if (cursor_col !== 6'd3 || cursor_row !== 4'd2) begin n_bad++; $display("FAIL arr_setup got=(%0d,%0d) exp=(3,2)", cursor_col, cursor_row); end
        key(10'h0E0);
        key(10'h075);
        er = ARROWS ? 4'd1 : 4'd2;
        n_vec++; if (en_mem !== 1'b0 || cursor_col !== 6'd3 || cursor_row !== er) begin n_bad++; $display("FAIL arr_up got=en%0b (%0d,%0d) exp=en0 (3,%0d)", en_mem, cursor_col, cursor_row, er); end
        key(10'h0E0);
        key(10'h0F0);
        key(10'h075);
        n_vec++; if (en_mem !== 1'b0 || cursor_col !== 6'd3 || cursor_row !== er) begin n_bad++; $display("FAIL arr_break got=en%0b (%0d,%0d) exp=en0 (3,%0d)", en_mem, cursor_col, cursor_row, er); end
        key(10'h0E0);
        key(10'h06B);
        ec = ARROWS ? 6'd2 : 6'd3;
        n_vec++; if (cursor_col !== ec || cursor_row !== er) begin n_bad++; $display("FAIL arr_left got=(%0d,%0d) exp=(%0d,%0d)", cursor_col, cursor_row, ec, er); end
        key(10'h007);
        n_vec++; if (en_mem !== 1'b1 || address !== (ARROWS ? 10'd42 : 10'd83)) begin n_bad++; $display("FAIL arr_ext_clr got=en%0b addr%0d exp=en1 addr%0d", en_mem, address, ARROWS ? 42 : 83); end
    endtask

    task automatic test_clear();
        int bad;
        int busy_cnt;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        bad = 0;
        busy_cnt = 0;
        for (int k = 0; k < 600; k++) begin
            if (en_mem !== 1'b1 || address !== 10'(k) || wr_data_mem !== 10'd0) bad++;
            if (busy === 1'b1) busy_cnt++;
            done = (k == 300);
            teclado = 10'h005;
            clear = (k == 200);
            @(negedge clk);
        end
        done = 1'b0;
        clear = 1'b0;
        n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL sweep_seq bad_cycles=%0d exp=0", bad); end
        n_vec++; if (busy_cnt !== 600) begin n_bad++; $display("FAIL sweep_busy got=%0d exp=600", busy_cnt); end
        n_vec++; if (busy !== 1'b0 || en_mem !== 1'b0) begin n_bad++; $display("FAIL sweep_end got=busy%0b en%0b exp=busy0 en0", busy, en_mem); end
        n_vec++; if (cursor_col !== 6'd0 || cursor_row !== 4'd0) begin n_bad++; $display("FAIL sweep_cursor got=(%0d,%0d) exp=(0,0)", cursor_col, cursor_row); end
        n_vec++; if (address !== 10'd599) begin n_bad++; $display("FAIL sweep_hold got=%0d exp=599", address); end
        teclado = 10'h003;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        n_vec++; if (en_mem !== 1'b1 || address !== 10'd0 || wr_data_mem !== 10'h003) begin n_bad++; $display("FAIL post_sweep got=en%0b addr%0d data%0h exp=en1 addr0 data3", en_mem, address, wr_data_mem); end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        clear = 1'b1;
        done = 1'b1;
        teclado = 10'h005;
        @(negedge clk);
        clear = 1'b0;
        done = 1'b0;
        n_vec++; if (busy !== 1'b1 || en_mem !== 1'b1 || address !== 10'd0 || wr_data_mem !== 10'd0) begin n_bad++; $display("FAIL clr_wins got=busy%0b en%0b addr%0d data%0h exp=busy1 en1 addr0 data0", busy, en_mem, address, wr_data_mem); end
        repeat (100) @(negedge clk);
        n_vec++; if (address !== 10'd100) begin n_bad++; $display("FAIL mid_addr got=%0d exp=100", address); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (busy !== 1'b0 || en_mem !== 1'b0 || address !== 10'd0 || wr_data_mem !== 10'd0) begin n_bad++; $display("FAIL abort got=busy%0b en%0b addr%0d data%0h exp=all0", busy, en_mem, address, wr_data_mem); end
        n_vec++; if (cursor_col !== 6'd0 || cursor_row !== 4'd0) begin n_bad++; $display("FAIL abort_cursor got=(%0d,%0d) exp=(0,0)", cursor_col, cursor_row); end
        key(10'h002);
        n_vec++; if (en_mem !== 1'b1 || address !== 10'd0 || wr_data_mem !== 10'h002) begin n_bad++; $display("FAIL after_abort got=en%0b addr%0d data%0h exp=en1 addr0 data2", en_mem, address, wr_data_mem); end
        n_vec++; if (cursor_col !== 6'd1 || cursor_row !== 4'd0) begin n_bad++; $display("FAIL after_abort_cursor got=(%0d,%0d) exp=(1,0)", cursor_col, cursor_row); end
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            teclado = 10'(i + 10);
            done = 1'b1;
            @(negedge clk);
            if (en_mem !== 1'b1 || address !== 10'(i) || wr_data_mem !== 10'(i + 10)) bad++;
        end
        done = 1'b0;
        n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL b2b bad_cycles=%0d exp=0", bad); end
        n_vec++; if (cursor_col !== 6'd5 || cursor_row !== 4'd0) begin n_bad++; $display("FAIL b2b_cursor got=(%0d,%0d) exp=(5,0)", cursor_col, cursor_row); end
    endtask

    initial begin
        test_reset();
        test_print_first();
        test_wrap();
        test_backspace();
        test_arrows();
        test_clear();
        test_rst_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/text_writer.md
# text_writer

Parametrised keyboard-to-character-memory writer for the VGA text console. It sits between the keyboard code translator (which produces `teclado`/`done`) and the character RAM write port, and maintains a COLS×ROWS cursor. It handles printable characters, Enter, Backspace, break and extended prefixes, and optional arrow-key cursor moves. A `clear` request runs a full-screen blanking sweep.

## Interface
Parameters:
- `COLS`, 40, characters per line
- `ROWS`, 15, lines per screen
- `CODE_W`, 10, translated key code width
- `DATA_W`, 10, character RAM data width (≥ CODE_W; code zero-extended)
- `PRINT_MAX`, 38, codes strictly below this are printable glyph indices
- Localparams: `ADDR_W = $clog2(COLS*ROWS)`, `COL_W = $clog2(COLS)`, `ROW_W = $clog2(ROWS)`

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset; overrides every other input
- `clear` in 1: single-cycle request to blank the screen
- `teclado` in CODE_W: translated key code, valid when `done`=1
- `done` in 1: one-cycle strobe marking a new `teclado`
- `address` out ADDR_W: registered RAM address, `row*COLS+col`
- `en_mem` out 1: registered one-cycle RAM write enable
- `wr_data_mem` out DATA_W: registered RAM write data
- `busy` out 1: high while a clear sweep is running
- `cursor_col` out COL_W, `cursor_row` out ROW_W: current cursor, zero-based

## Operation
- Codes: break 0x0F0, extended prefix 0x0E0, Enter 0x0C0, Backspace 0x108. Arrows follow 0x0E0: left 0x06B, right 0x074, up 0x075, down 0x072.
- FSM states are IDLE and CLEAR. On reset: IDLE, all outputs 0, cursor (0,0), `ign`=0, `ext`=0.
- IDLE, `done`=1, `ign`=1: code is discarded; `ign` and `ext` clear; no write.
- 0x0F0 sets `ign`. 0x0E0 sets `ext`. Neither writes. `ext` stays set through a following 0x0F0.
- `ext`=1 and code is not 0x0F0: the code goes to arrow handling (see Configuration); `ext` clears.
- Printable (`ext`=0, code < PRINT_MAX): write `code` at the current cursor, then advance the cursor.
- Advance rule: col+1. If col = COLS-1, col goes to 0 and row+1. Row ROWS-1 wraps to 0.
- Enter: col goes to 0 and row advances with the same wrap. No write.
- Backspace: retreat the cursor, then write 0 at the retreated position.
- Retreat rule: col-1. If col = 0, col goes to COLS-1 and row-1. Row 0 wraps to ROWS-1.
- Any other code: discarded; flags unchanged.
- `clear`=1 in IDLE: enter CLEAR and set the sweep counter to 0. Each CLEAR cycle writes 0 at the counter value, then increments it. After address COLS*ROWS-1: cursor goes to (0,0), `ign`/`ext` clear, state returns to IDLE.
- In CLEAR, `done` and `clear` are ignored; codes are dropped and not queued.
- `clear` and `done` in the same IDLE cycle: `clear` wins and the code is dropped.
- `rst` mid-sweep: aborts immediately to reset state.

## Timing
- `done` in cycle N: `en_mem`, `address`, `wr_data_mem` valid in N+1. The cursor outputs update at the same edge.
- `en_mem` is high for exactly one cycle per write. Back-to-back `done` strobes are sustained at one per cycle.
- Between writes, `address` and `wr_data_mem` hold their last values.
- `clear` in cycle N: `en_mem`=`busy`=1 in cycles N+1…N+COLS*ROWS, with addresses 0…COLS*ROWS-1 in order. `busy`=0 from N+COLS*ROWS+1, and `done` is accepted from that cycle.
- The cursor outputs read (0,0) from N+COLS*ROWS+1.

## Configuration
- `TEXT_WRITER_ARROWS_EN` defined: arrows move the cursor without writing.
  - Left uses the retreat rule; right uses the advance rule.
  - Up/down step row ∓1/±1 with wrap; col is unchanged.
  - Non-arrow codes after 0x0E0 are discarded.
- Not defined: every code following 0x0E0 is discarded. The prefix is still consumed, and no cursor move or write occurs.

## Test plan
- Reset, then `done` with 0x005 at (0,0) → next cycle `en_mem`=1, `address`=0, `wr_data_mem`=0x005; cursor (1,0).
- Write 40 printable codes from (0,0), then 0x001 → 41st write at `address`=40, cursor (1,1). Cursor at (39,14) plus one printable → write at 599, cursor (0,0).
- At (0,0), 0x108 → write 0 at `address`=599, cursor (39,14). Then 0x0F0 followed by 0x005 → no write, cursor unchanged.
- With ARROWS_EN, at (3,2): 0x0E0, 0x075 → cursor (3,1), no write. Then 0x0E0, 0x0F0, 0x075 → no move. Without the macro, the same first pair → cursor stays (3,2).
- `clear` pulse → 600 consecutive `en_mem` cycles, addresses 0…599, data 0. `busy` high for exactly 600 cycles. `done` strobed mid-sweep is dropped. Cursor (0,0) afterwards.
- `rst` asserted at sweep cycle 100 → the next cycle shows all outputs 0 and `busy`=0. A subsequent `done` 0x002 writes at `address`=0.
